// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronise and debounce push-button pins into level plus press/release strobes
//
// Each of WIDTH asynchronous button pins passes through a two-flop synchroniser and is then mapped
// to "1 = pressed" (inverted when ACTIVE_LOW). A four-state FSM per channel only accepts a new
// level once it has been seen for STABLE_CYCLES consecutive cycles. Any disagreeing sample during
// the check aborts it.
//
// Ports:
//   clock          system clock, all logic on posedge
//   resetn         asynchronous active-low reset
//   buttons_pio    raw asynchronous button pins [WIDTH]
//   pressed        debounced level, 1 = pressed [WIDTH]
//   press_pulse    one-cycle strobe when pressed[i] rises [WIDTH]
//   release_pulse  one-cycle strobe when pressed[i] falls [WIDTH]
//   any_change     OR of all press/release strobes in the same cycle
module button_debouncer #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 1330000,
    parameter int CNT_WIDTH     = 21,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] buttons_pio,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic             any_change
);

    localparam logic                 ACTIVE_LOW_BIT = (ACTIVE_LOW != 0);
    // Pin value that means "released"; the synchroniser resets to it so reset never looks like a press.
    localparam logic [WIDTH-1:0]     IDLE_PINS      = {WIDTH{ACTIVE_LOW_BIT}};
    localparam logic [CNT_WIDTH-1:0] CNT_LAST       = CNT_WIDTH'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        CHECK_PRESS,
        PRESSED,
        CHECK_RELEASE
    } state_t;

    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;
    logic [WIDTH-1:0] s;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q1 <= IDLE_PINS;
            sync_q2 <= IDLE_PINS;
        end else begin
            sync_q1 <= buttons_pio;
            sync_q2 <= sync_q1;
        end
    end

    // Polarity mapping sits after the second flop so the synchroniser only ever sees raw pins.
    assign s = sync_q2 ^ IDLE_PINS;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        state_t               state;
        state_t               state_nxt;
        logic [CNT_WIDTH-1:0] cnt;
        logic [CNT_WIDTH-1:0] cnt_nxt;
        logic                 level_q;
        logic                 level_nxt;
        logic                 press_q;
        logic                 press_nxt;
        logic                 release_q;
        logic                 release_nxt;

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                state     <= RELEASED;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
            end
        end

        // cnt holds how many consecutive cycles the candidate level has been seen; entering a
        // CHECK state already counts the first one, so acceptance is on the STABLE_CYCLES-th.
        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            level_nxt   = level_q;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            case (state)
                RELEASED: begin
                    if (s[i]) begin
                        state_nxt = CHECK_PRESS;
                        cnt_nxt   = CNT_WIDTH'(1);
                    end else begin
                        cnt_nxt   = '0;
                    end
                end
                CHECK_PRESS: begin
                    if (!s[i]) begin
                        state_nxt = RELEASED;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                        level_nxt = 1'b1;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_nxt   = cnt + CNT_WIDTH'(1);
                    end
                end
                PRESSED: begin
                    if (!s[i]) begin
                        state_nxt = CHECK_RELEASE;
                        cnt_nxt   = CNT_WIDTH'(1);
                    end else begin
                        cnt_nxt   = '0;
                    end
                end
                CHECK_RELEASE: begin
                    if (s[i]) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt   = RELEASED;
                        cnt_nxt     = '0;
                        level_nxt   = 1'b0;
                        release_nxt = 1'b1;
                    end else begin
                        cnt_nxt     = cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                end
            endcase
        end

        assign pressed[i]       = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
    end

    // Built from registered strobes only, so there is still no path from the pins to any output.
    assign any_change = (|press_pulse) | (|release_pulse);

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for button_debouncer
module tb_button_debouncer;

    localparam int W  = 4;
    localparam int SC = 8;

    logic         clock;
    logic         resetn;
    logic [W-1:0] buttons_pio;
    logic [W-1:0] pressed;
    logic [W-1:0] press_pulse;
    logic [W-1:0] release_pulse;
    logic         any_change;

    button_debouncer #(
        .WIDTH(W),
        .STABLE_CYCLES(SC),
        .CNT_WIDTH(4),
        .ACTIVE_LOW(1)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .buttons_pio(buttons_pio),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .any_change(any_change)
    );

    typedef struct {
        int         cyc;
        logic [3:0] pm;
        logic [3:0] rm;
    } ev_t;

    ev_t q[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Pins driven just after edge `cyc` are first sampled on edge cyc+1, so the strobe lands on cyc+10.
    task automatic expect_ev(input int at, input logic [3:0] pm, input logic [3:0] rm);
        ev_t e;
        e.cyc = at;
        e.pm  = pm;
        e.rm  = rm;
        q.push_back(e);
    endtask

    task automatic check_pressed(input string name, input logic [3:0] exp);
        total++;
        if (pressed !== exp) begin
            bad++;
            $display("FAIL %s: pressed=%b expected=%b at cycle %0d", name, pressed, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        ev_t e;
        total++;
        if (any_change !== |(press_pulse | release_pulse)) begin
            bad++;
            $display("FAIL any_change: got=%b pulses p=%b r=%b cycle %0d",
                     any_change, press_pulse, release_pulse, cyc);
        end
        if ((press_pulse | release_pulse) != 0) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: p=%b r=%b at cycle %0d, none expected",
                         press_pulse, release_pulse, cyc);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.pm !== press_pulse || e.rm !== release_pulse) begin
                    bad++;
                    $display("FAIL pulse: got p=%b r=%b cycle %0d expected p=%b r=%b cycle %0d",
                             press_pulse, release_pulse, cyc, e.pm, e.rm, e.cyc);
                end
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            total++;
            bad++;
            e = q.pop_front();
            $display("FAIL missing_pulse: got none by cycle %0d expected p=%b r=%b cycle %0d",
                     cyc, e.pm, e.rm, e.cyc);
        end
    end

    initial begin
        int n;
        buttons_pio = 4'hF;
        resetn      = 1'b0;
        step(3);
        check_pressed("reset", 4'b0000);
        resetn = 1'b1;

        // idle: no pulses allowed for 100 cycles
        step(100);
        check_pressed("idle", 4'b0000);

        // clean press and release on pin0
        buttons_pio[0] = 1'b0;
        expect_ev(cyc + 10, 4'b0001, 4'b0000);
        step(12);
        check_pressed("press0", 4'b0001);
        buttons_pio[0] = 1'b1;
        expect_ev(cyc + 10, 4'b0000, 4'b0001);
        step(12);
        check_pressed("release0", 4'b0000);

        // bounce every 3 cycles for 40 cycles, then settle low
        for (int t = 0; t < 42; t++) begin
            if (t % 3 == 0) buttons_pio[0] = ~buttons_pio[0];
            step(1);
        end
        check_pressed("bounce", 4'b0000);
        buttons_pio[0] = 1'b0;
        expect_ev(cyc + 10, 4'b0001, 4'b0000);
        step(12);
        check_pressed("bounce_settle", 4'b0001);
        buttons_pio[0] = 1'b1;
        expect_ev(cyc + 10, 4'b0000, 4'b0001);
        step(12);

        // simultaneous events on pins 1 and 3
        buttons_pio[1] = 1'b0;
        buttons_pio[3] = 1'b0;
        expect_ev(cyc + 10, 4'b1010, 4'b0000);
        step(12);
        check_pressed("press13", 4'b1010);
        buttons_pio[1] = 1'b1;
        buttons_pio[3] = 1'b1;
        expect_ev(cyc + 10, 4'b0000, 4'b1010);
        step(12);
        check_pressed("release13", 4'b0000);

        // boundary: 7 cycles rejected, 8 cycles accepted
        buttons_pio[1] = 1'b0;
        step(7);
        buttons_pio[1] = 1'b1;
        step(12);
        check_pressed("hold7", 4'b0000);
        n = cyc;
        buttons_pio[1] = 1'b0;
        expect_ev(n + 10, 4'b0010, 4'b0000);
        step(8);
        buttons_pio[1] = 1'b1;
        expect_ev(n + 18, 4'b0000, 4'b0010);
        step(3);
        check_pressed("hold8", 4'b0010);
        step(12);
        check_pressed("hold8_release", 4'b0000);

        // reset mid-debounce with pin3 already pressed and pin2 at cnt=5
        buttons_pio[3] = 1'b0;
        expect_ev(cyc + 10, 4'b1000, 4'b0000);
        step(12);
        check_pressed("press3", 4'b1000);
        buttons_pio[2] = 1'b0;
        step(7);
        resetn = 1'b0;
        #2;
        check_pressed("async_reset", 4'b0000);
        total++;
        if ((press_pulse | release_pulse) !== 4'b0000 || any_change !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_pulses: p=%b r=%b any=%b expected zero",
                     press_pulse, release_pulse, any_change);
        end
        step(3);
        resetn = 1'b1;
        expect_ev(cyc + 10, 4'b1100, 4'b0000);
        step(14);
        check_pressed("post_reset", 4'b1100);

        step(5);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: %0d events left expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
